fetch_addr_gen: RTL and testbench
=================================

# fetch_addr_gen

Parametrised instruction-fetch address generator for the single-cycle CPU. It owns the fetch PC, converts byte PCs into word addresses for a synchronous instruction ROM of any depth and base, and tracks in-flight reads through a configurable ROM latency. Each returned word is tagged with its PC, and misaligned or out-of-range fetches are reported as faults. It sits between branch/redirect logic and the instruction ROM, feeding the decode stage.

## Interface
- PC_WIDTH, 32, fetch PC width in bits
- ROM_ADDR_WIDTH, 5, ROM word-address width; depth = 2**ROM_ADDR_WIDTH
- BYTES_PER_WORD, 4, power of two ≥1; shift = log2(BYTES_PER_WORD)
- ROM_BASE, 0, byte address of ROM word 0; must be word-aligned
- RESET_PC, 0, PC value loaded at reset
- ROM_LATENCY, 1, ROM read latency in cycles (1 or 2)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- stall  in  1  freeze fetch; ROM and tag pipeline hold
- redirect_valid  in  1  load redirect_pc this cycle
- redirect_pc  in  PC_WIDTH  new fetch PC
- rom_addr  out  ROM_ADDR_WIDTH  ROM word address
- rom_en  out  1  ROM clock enable / read strobe
- instr_valid  out  1  ROM data for instr_pc is valid this cycle
- instr_pc  out  PC_WIDTH  PC of the word currently on ROM data
- fault  out  1  fetch fault latched
- fault_cause  out  2  01 misaligned, 10 out of range, 00 none
- fault_pc  out  PC_WIDTH  PC that faulted

## Operation
- States: IDLE (held during reset), RUN, FAULT.
- IDLE -> RUN on the first clk edge after reset deasserts.
- Offset: off = pc_q - ROM_BASE, computed modulo 2**PC_WIDTH.
- Misaligned: pc_q[shift-1:0] != 0.
- Out of range: off >= depth*BYTES_PER_WORD; this covers pc_q < ROM_BASE through the unsigned wrap of off.
- rom_addr = off[shift +: ROM_ADDR_WIDTH]. It is combinational from pc_q, so it is always defined.
- In RUN, with no stall, no redirect and no fault condition: rom_en=1, pc_q <= pc_q + BYTES_PER_WORD, and the tag {valid=1, pc_q} enters the tag pipeline.
- When a fault condition exists in RUN: no issue, rom_en=0, state -> FAULT. fault, fault_cause and fault_pc latch on that edge. If both conditions hold, misaligned takes priority.
- FAULT: no issue; outputs hold; in-flight tags drain normally. Only redirect or reset leaves FAULT.
- redirect_valid (any state except IDLE):
  - pc_q <= redirect_pc.
  - All in-flight tags are flushed; they will never raise instr_valid.
  - fault clears and state -> RUN.
  - No issue in the redirect cycle.
- Priority, highest first: reset > redirect > stall > issue.
- stall (without redirect): rom_en=0, pc_q holds, and the tag pipeline holds with instr_valid/instr_pc stable. The ROM holds its output because rom_en=0.
- PC increment wraps modulo 2**PC_WIDTH; no special handling beyond the range check.

## Timing
- Reset values:
  - pc_q=RESET_PC; state=IDLE
  - rom_en=0; rom_addr = mapping of RESET_PC
  - instr_valid=0; instr_pc=0
  - fault=0; fault_cause=00; fault_pc=0
- Issue-to-valid latency is exactly ROM_LATENCY unstalled cycles: a word issued at edge N yields instr_valid after edge N+ROM_LATENCY.
- Throughput is one word per cycle in RUN without stall.
- The first issue happens in the cycle after IDLE -> RUN.
- After a redirect, the first issue is the cycle after the redirect edge; the bubble is 1 + ROM_LATENCY cycles.
- fault asserts the cycle after the offending pc_q is presented.
- Reset mid-operation clears all tags immediately (asynchronous); no instr_valid appears after reset.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN, FAULT}
  - fault-cause constants FC_NONE, FC_MISALIGN, FC_RANGE
- Sub-module fetch_tag_pipe: a ROM_LATENCY-deep shift register of {valid, pc}, with enable (!stall), synchronous flush (redirect) and asynchronous reset.
- Top level contains the PC register, mapping/range logic and FSM.

## Test plan
- Defaults, release reset, no stall:
  - rom_addr 0,1,2,3 on consecutive issue cycles.
  - instr_valid with instr_pc 0x0,0x4,0x8,0xC, each one cycle later.
- Run to 0x7C, then next PC 0x80:
  - 0x7C issues rom_addr 31.
  - Then fault=1, fault_cause=10, fault_pc=0x80, rom_en=0.
  - 0x7C tag still delivered.
- Redirect to 0x0C while in flight:
  - In-flight tag dropped.
  - Next issue rom_addr=3; instr_pc=0x0C arrives after ROM_LATENCY.
- Redirect to 0x06: fault_cause=01, fault_pc=0x06. Then redirect to 0x10: fault clears, rom_addr=4.
- stall for 3 cycles mid-stream:
  - rom_en=0; pc_q, instr_valid and instr_pc frozen.
  - Sequence resumes with no gaps or duplicates.
  - With stall and redirect together, redirect wins.
- ROM_LATENCY=2, ROM_BASE=0x100: PC 0x104 gives rom_addr 1 and instr_valid two cycles later. Assert reset mid-stream: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch address generator.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;

  // Misalignment outranks an out-of-range address when both apply.
  function automatic logic [1:0] fault_cause_sel(input logic misalign,
                                                 input logic out_of_range);
    if (misalign)     return FC_MISALIGN;
    if (out_of_range) return FC_RANGE;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/fetch_tag_pipe.sv
// Shift register of {valid, pc} tags that tracks ROM reads in flight.
// The tag leaving the last stage describes the word on the ROM data bus.
module fetch_tag_pipe #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned LATENCY  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic                valid_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                valid_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic                valid_q [LATENCY];
  logic [PC_WIDTH-1:0] pc_q    [LATENCY];

  // Flush drops every tag even while stalled; otherwise shift only when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        pc_q[i]    <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        pc_q[i]    <= '0;
      end
    end else if (en_i) begin
      valid_q[0] <= valid_i;
      pc_q[0]    <= pc_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        pc_q[i]    <= pc_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign pc_o    = pc_q[LATENCY-1];

endmodule

// File: rtl/fetch_addr_gen.sv
// Instruction-fetch address generator: owns the fetch PC, maps it onto a
// synchronous instruction ROM, tags returned words and reports fetch faults.
module fetch_addr_gen
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH       = 32,
  parameter int unsigned          ROM_ADDR_WIDTH = 5,
  parameter int unsigned          BYTES_PER_WORD = 4,
  parameter logic [PC_WIDTH-1:0]  ROM_BASE       = '0,
  parameter logic [PC_WIDTH-1:0]  RESET_PC       = '0,
  parameter int unsigned          ROM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [PC_WIDTH-1:0]       redirect_pc,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic                      rom_en,
  output logic                      instr_valid,
  output logic [PC_WIDTH-1:0]       instr_pc,
  output logic                      fault,
  output logic [1:0]                fault_cause,
  output logic [PC_WIDTH-1:0]       fault_pc
);

  localparam int unsigned         SHIFT      = $clog2(BYTES_PER_WORD);
  localparam logic [PC_WIDTH:0]   ROM_BYTES  = (PC_WIDTH+1)'(BYTES_PER_WORD) << ROM_ADDR_WIDTH;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(BYTES_PER_WORD - 1);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                fault_q, fault_d;
  logic [1:0]          cause_q, cause_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;

  logic [PC_WIDTH-1:0] off;
  logic                misalign;
  logic                out_of_range;
  logic                issue;
  logic                flush;

  // Offset wraps, so a PC below ROM_BASE lands far above the ROM and reads as out of range.
  assign off          = pc_q - ROM_BASE;
  assign misalign     = |(pc_q & ALIGN_MASK);
  assign out_of_range = {1'b0, off} >= ROM_BYTES;
  assign rom_addr     = ROM_ADDR_WIDTH'(off >> SHIFT);

  // Next-state, PC and fault bookkeeping; priority is redirect > stall > issue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cause_d = cause_q;
    fpc_d   = fpc_q;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (stall) begin
          // hold everything
        end else if (misalign || out_of_range) begin
          state_d = FAULT;
          fault_d = 1'b1;
          cause_d = fault_cause_sel(misalign, out_of_range);
          fpc_d   = pc_q;
        end else begin
          issue = 1'b1;
          pc_d  = pc_q + PC_WIDTH'(BYTES_PER_WORD);
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          state_d = RUN;
          pc_d    = redirect_pc;
          flush   = 1'b1;
          fault_d = 1'b0;
          cause_d = FC_NONE;
          fpc_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cause_q <= FC_NONE;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      fpc_q   <= fpc_d;
    end
  end

  assign rom_en      = issue;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_pc    = fpc_q;

  fetch_tag_pipe #(
    .PC_WIDTH (PC_WIDTH),
    .LATENCY  (ROM_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .en_i    (!stall),
    .flush_i (flush),
    .valid_i (issue),
    .pc_i    (pc_q),
    .valid_o (instr_valid),
    .pc_o    (instr_pc)
  );

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Scoreboard bench for fetch_addr_gen: two instances (default, and
// ROM_LATENCY=2 with ROM_BASE=0x100) driven by shared stimulus.
module tb_fetch_addr_gen;

  typedef struct {
    logic [31:0] pc;
    int unsigned due;
  } tag_t;

  localparam logic [31:0] BASE_A  [2] = '{32'h0, 32'h100};
  localparam logic [31:0] RESET_A [2] = '{32'h0, 32'h100};
  localparam int unsigned LAT_A   [2] = '{1, 2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [4:0]  rom_addr_w    [2];
  logic        rom_en_w      [2];
  logic        instr_valid_w [2];
  logic [31:0] instr_pc_w    [2];
  logic        fault_w       [2];
  logic [1:0]  fault_cause_w [2];
  logic [31:0] fault_pc_w    [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_addr_gen u_dut0 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr_w[0]), .rom_en(rom_en_w[0]),
    .instr_valid(instr_valid_w[0]), .instr_pc(instr_pc_w[0]),
    .fault(fault_w[0]), .fault_cause(fault_cause_w[0]), .fault_pc(fault_pc_w[0])
  );

  fetch_addr_gen #(
    .ROM_BASE    (32'h100),
    .RESET_PC    (32'h100),
    .ROM_LATENCY (2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr_w[1]), .rom_en(rom_en_w[1]),
    .instr_valid(instr_valid_w[1]), .instr_pc(instr_pc_w[1]),
    .fault(fault_w[1]), .fault_cause(fault_cause_w[1]), .fault_pc(fault_pc_w[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  tag_t        mq0[$];
  tag_t        mq1[$];
  logic [31:0] mpc    [2];
  bit          midle  [2];
  bit          mfault [2];
  logic [1:0]  mcause [2];
  logic [31:0] mfpc   [2];
  bit          last_v [2];
  logic [31:0] last_pc[2];
  int unsigned ucnt;
  bit          adv;

  function automatic int q_size(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic q_push(input int d, input tag_t t);
    if (d == 0) mq0.push_back(t); else mq1.push_back(t);
  endtask

  task automatic q_pop(input int d, output tag_t t);
    if (d == 0) t = mq0.pop_front(); else t = mq1.pop_front();
  endtask

  task automatic q_clear(input int d);
    if (d == 0) mq0.delete(); else mq1.delete();
  endtask

  function automatic int unsigned q_head_due(input int d);
    return (d == 0) ? mq0[0].due : mq1[0].due;
  endfunction

  task automatic model_init();
    for (int d = 0; d < 2; d++) begin
      q_clear(d);
      mpc[d]     = RESET_A[d];
      midle[d]   = 1'b1;
      mfault[d]  = 1'b0;
      mcause[d]  = 2'b00;
      mfpc[d]    = '0;
      last_v[d]  = 1'b0;
      last_pc[d] = '0;
    end
    ucnt = 0;
    adv  = 1'b0;
  endtask

  // One clock edge of the fetch rules: start up, redirect, hold, fault or fetch a word.
  task automatic model_step(input int d);
    logic [31:0] off;
    tag_t t;
    off = mpc[d] - BASE_A[d];
    if (midle[d]) begin
      midle[d] = 1'b0;
    end else if (redirect_valid) begin
      mpc[d]    = redirect_pc;
      mfault[d] = 1'b0;
      q_clear(d);
    end else if (stall || mfault[d]) begin
    end else if (mpc[d] % 4 != 0) begin
      mfault[d] = 1'b1; mcause[d] = 2'b01; mfpc[d] = mpc[d];
    end else if (off >= 32'd128) begin
      mfault[d] = 1'b1; mcause[d] = 2'b10; mfpc[d] = mpc[d];
    end else begin
      t.pc  = mpc[d];
      t.due = ucnt + LAT_A[d] - 1;
      q_push(d, t);
      mpc[d] = mpc[d] + 32'd4;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_init();
    end else begin
      adv = !stall || redirect_valid;
      if (adv) ucnt++;
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] off;
        bit          exp_en;
        tag_t        t;
        off    = mpc[d] - BASE_A[d];
        exp_en = !midle[d] && !mfault[d] && !redirect_valid && !stall &&
                 (mpc[d] % 4 == 0) && (off < 32'd128);
        chk("rom_en", d, 32'(rom_en_w[d]), 32'(exp_en));
        chk("rom_addr", d, 32'(rom_addr_w[d]), (off >> 2) & 32'h1f);
        if (adv) begin
          if (q_size(d) > 0 && q_head_due(d) == ucnt) begin
            q_pop(d, t);
            last_v[d]  = 1'b1;
            last_pc[d] = t.pc;
          end else begin
            last_v[d] = 1'b0;
          end
        end
        chk("instr_valid", d, 32'(instr_valid_w[d]), 32'(last_v[d]));
        if (last_v[d]) chk("instr_pc", d, instr_pc_w[d], last_pc[d]);
        chk("fault", d, 32'(fault_w[d]), 32'(mfault[d]));
        chk("fault_cause", d, 32'(fault_cause_w[d]), mfault[d] ? 32'(mcause[d]) : 32'd0);
        if (mfault[d]) chk("fault_pc", d, fault_pc_w[d], mfpc[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit st, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic run(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_values();
    for (int d = 0; d < 2; d++) begin
      chk("rst_rom_en", d, 32'(rom_en_w[d]), 32'd0);
      chk("rst_rom_addr", d, 32'(rom_addr_w[d]), ((RESET_A[d] - BASE_A[d]) >> 2) & 32'h1f);
      chk("rst_instr_valid", d, 32'(instr_valid_w[d]), 32'd0);
      chk("rst_instr_pc", d, instr_pc_w[d], 32'd0);
      chk("rst_fault", d, 32'(fault_w[d]), 32'd0);
      chk("rst_fault_cause", d, 32'(fault_cause_w[d]), 32'd0);
      chk("rst_fault_pc", d, fault_pc_w[d], 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 31)) * 4;
      1:       return 32'h100 + 32'($urandom_range(0, 31)) * 4;
      2:       return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      3:       return 32'h70 + 32'($urandom_range(0, 3)) * 4;
      4:       return 32'h170 + 32'($urandom_range(0, 3)) * 4;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #13;
    check_reset_values();
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    // sequential fetch up to the end of ROM and into the range fault
    run(40);
    // redirect recovery, redirect while words are in flight
    drive(1'b0, 1'b1, 32'h0C);
    run(3);
    drive(1'b0, 1'b1, 32'h104);
    run(4);
    drive(1'b0, 1'b1, 32'h06);
    run(3);
    drive(1'b0, 1'b1, 32'h10);
    run(3);
    drive(1'b0, 1'b1, 32'h110);
    run(3);
    // stall mid-stream, then stall together with redirect
    repeat (3) drive(1'b1, 1'b0, 32'h0);
    run(3);
    drive(1'b1, 1'b1, 32'h100);
    run(5);
    // randomized stall / redirect traffic
    for (int i = 0; i < 500; i++) begin
      bit st, rv;
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      drive(st, rv, rand_pc());
    end
    // reset mid-stream returns every output to its reset value at once
    drive(1'b0, 1'b1, 32'h104);
    run(4);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values();
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    run(12);
    @(posedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
